// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  uart_pkg
//  Shared UART constants and the loopback controller state encoding.
//  Rev 1.0
// ============================================================================
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_DONE    = 2'd3
    } loop_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  uart_loop_ctrl
//  Sends an NBYTES message through a UART loopback, checks every echoed byte
//  against the latched copy and counts bad, corrupted or missing bytes.
//  Rev 1.0
// ============================================================================
module uart_loop_ctrl
    import uart_pkg::*;
#(
    parameter int NBYTES  = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [BYTE_W*NBYTES-1:0]                 msg,
    output logic [BYTE_W-1:0]                        Tx_DATA,
    output logic                                     Tx_WR,
    output logic                                     Tx_EN,
    output logic                                     Rx_EN,
    input  logic                                     Tx_BUSY,
    input  logic [BYTE_W-1:0]                        Rx_DATA,
    input  logic                                     Rx_VALID,
    input  logic                                     Rx_PERROR,
    input  logic                                     Rx_FERROR,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     pass,
    output logic [$clog2(NBYTES+1)-1:0]              err_count,
    output logic [((NBYTES > 1) ? $clog2(NBYTES) : 1)-1:0] byte_idx
);

    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NBYTES);

    loop_state_e                state_q;
    logic [BYTE_W*NBYTES-1:0]   msg_q;
    logic [IDX_W-1:0]           byte_idx_q;
    logic [CNT_W-1:0]           err_count_q;
    logic [TMR_W-1:0]           timer_q;
    logic                       rx_valid_q;
    logic [BYTE_W-1:0]          tx_data_q;
    logic                       tx_wr_q;
    logic                       en_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       pass_q;

    logic [BYTE_W-1:0]          cur_byte;
    logic                       rx_edge;
    logic                       timeout_hit;
    logic                       byte_fail;
    logic [CNT_W-1:0]           err_count_d;

    assign cur_byte    = msg_q[int'(byte_idx_q)*BYTE_W +: BYTE_W];
    assign rx_edge     = Rx_VALID & ~rx_valid_q;
    assign timeout_hit = (timer_q == TMR_LAST);

    // A reception in the timeout cycle wins, so a late-but-good echo still passes.
    assign byte_fail   = rx_edge ? ((Rx_DATA != cur_byte) | Rx_PERROR | Rx_FERROR) : 1'b1;

    assign err_count_d = (byte_fail && (err_count_q != CNT_MAX)) ? err_count_q + 1'b1
                                                                  : err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            msg_q       <= '0;
            byte_idx_q  <= '0;
            err_count_q <= '0;
            timer_q     <= '0;
            rx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_wr_q     <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            rx_valid_q <= Rx_VALID;
            tx_wr_q    <= 1'b0;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        msg_q       <= msg;
                        byte_idx_q  <= '0;
                        err_count_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        en_q        <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (!Tx_BUSY) begin
                        tx_data_q <= cur_byte;
                        tx_wr_q   <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= ST_WAIT_RX;
                    end
                end

                ST_WAIT_RX: begin
                    if (rx_edge || timeout_hit) begin
                        err_count_q <= err_count_d;
                        if (byte_idx_q == IDX_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            en_q    <= 1'b0;
                            pass_q  <= (err_count_d == '0);
                            state_q <= ST_DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            state_q    <= ST_SEND;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Tx_DATA   = tx_data_q;
    assign Tx_WR     = tx_wr_q;
    assign Tx_EN     = en_q;
    assign Rx_EN     = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign byte_idx  = byte_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_loop_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_uart_loop_ctrl
//  Loopback echo model with per-byte fault injection and an error-count model.
//  Rev 1.0
// ============================================================================
module tb_uart_loop_ctrl;

    localparam int NB = 4;
    localparam int TO = 50;
    localparam int CW = $clog2(NB + 1);
    localparam int IW = 2;

    // Echo behaviour per byte
    localparam int M_GOOD = 0;
    localparam int M_BAD  = 1;
    localparam int M_PERR = 2;
    localparam int M_FERR = 3;
    localparam int M_MUTE = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [8*NB-1:0] msg;
    logic [7:0]      Tx_DATA;
    logic            Tx_WR, Tx_EN, Rx_EN;
    logic            Tx_BUSY;
    logic [7:0]      Rx_DATA;
    logic            Rx_VALID, Rx_PERROR, Rx_FERROR;
    logic            busy, done, pass;
    logic [CW-1:0]   err_count;
    logic [IW-1:0]   byte_idx;

    int         tests = 0;
    int         fails = 0;
    int         mode [NB];
    int         dly  [NB];
    int         rsp_k;
    bit         busy_rand;
    logic [7:0] sent_q [$];

    always #5 clk = ~clk;

    uart_loop_ctrl #(.NBYTES(NB), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .msg      (msg),
        .Tx_DATA  (Tx_DATA),
        .Tx_WR    (Tx_WR),
        .Tx_EN    (Tx_EN),
        .Rx_EN    (Rx_EN),
        .Tx_BUSY  (Tx_BUSY),
        .Rx_DATA  (Rx_DATA),
        .Rx_VALID (Rx_VALID),
        .Rx_PERROR(Rx_PERROR),
        .Rx_FERROR(Rx_FERROR),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .byte_idx (byte_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: every byte whose echo is not a clean copy costs one error.
    function automatic int model_errors();
        int n = 0;
        for (int i = 0; i < NB; i++)
            if (mode[i] != M_GOOD) n++;
        return (n > NB) ? NB : n;
    endfunction

    // Echo model standing in for the transmitter->receiver loopback.
    initial begin : responder
        int         k;
        logic [7:0] b;
        Rx_VALID  = 1'b0;
        Rx_DATA   = 8'h00;
        Rx_PERROR = 1'b0;
        Rx_FERROR = 1'b0;
        forever begin
            @(negedge clk);
            if (Tx_WR === 1'b1 && reset !== 1'b1) begin
                b = Tx_DATA;
                sent_q.push_back(b);
                k = rsp_k;
                rsp_k++;
                if (k < NB && mode[k] != M_MUTE) begin
                    for (int i = 0; i < dly[k] && reset !== 1'b1; i++) @(negedge clk);
                    if (reset !== 1'b1) begin
                        Rx_DATA   = (mode[k] == M_BAD) ? ((b == 8'h00) ? 8'hFF : 8'h00) : b;
                        Rx_PERROR = (mode[k] == M_PERR);
                        Rx_FERROR = (mode[k] == M_FERR);
                        Rx_VALID  = 1'b1;
                        @(negedge clk);
                        Rx_VALID  = 1'b0;
                        Rx_PERROR = 1'b0;
                        Rx_FERROR = 1'b0;
                        Rx_DATA   = 8'($urandom);
                    end
                end
            end
        end
    end

    initial begin : busy_gen
        Tx_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            Tx_BUSY = busy_rand && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
        for (int i = 0; i < NB; i++) dly[i] = $urandom_range(0, 10);
    endtask

    // Start a run, optionally poke start again mid-run, and wait for done.
    task automatic run(input logic [8*NB-1:0] m, input int poke, output int cyc);
        rsp_k = 0;
        sent_q.delete();
        @(negedge clk);
        msg   = m;
        start = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            msg   = $urandom;
            if (cyc == 2) check("run_active", {busy, Tx_EN, Rx_EN, done}, 4'b1110);
            if (cyc == poke) start = 1'b1;
        end while (done !== 1'b1 && cyc < 3000);
        start = 1'b0;
        check("done_reached", done, 1'b1);
    endtask

    task automatic finish_checks(input string tag, input logic [8*NB-1:0] m);
        logic [8*NB-1:0] got;
        int              exp_err;
        got     = '0;
        exp_err = model_errors();
        for (int i = 0; i < sent_q.size() && i < NB; i++) got[8*i +: 8] = sent_q[i];
        check({tag, "_sent_count"}, sent_q.size(), NB);
        check({tag, "_sent_order"}, got, m);
        check({tag, "_err_count"}, err_count, exp_err);
        check({tag, "_pass"}, pass, (exp_err == 0));
        check({tag, "_idle_outputs"}, {busy, Tx_EN, Rx_EN}, 3'b000);
    endtask

    initial begin : stim
        int              cyc;
        logic [8*NB-1:0] m;

        reset     = 1'b1;
        start     = 1'b0;
        msg       = '0;
        busy_rand = 1'b0;
        rsp_k     = 0;
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);

        repeat (3) @(negedge clk);
        start = 1'b1;
        msg   = 32'hDEAD_BEEF;
        @(negedge clk);
        check("reset_state", {Tx_DATA, Tx_WR, Tx_EN, Rx_EN, busy, done, pass, err_count, byte_idx}, '0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_in_reset_ignored", {busy, Tx_EN, done}, 3'b000);

        // Clean loopback
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        run(32'hA55A_0FF0, -1, cyc);
        finish_checks("clean", 32'hA55A_0FF0);

        // Corrupted echo on byte 2
        set_modes(M_GOOD, M_GOOD, M_BAD, M_GOOD);
        run(32'hA55A_0FF0, -1, cyc);
        finish_checks("bad_byte2", 32'hA55A_0FF0);

        // Parity error with correct data on byte 0
        set_modes(M_PERR, M_GOOD, M_GOOD, M_GOOD);
        run(32'h1234_5678, -1, cyc);
        finish_checks("perr_byte0", 32'h1234_5678);

        // Framing error on the last byte
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_FERR);
        run(32'h0102_0304, -1, cyc);
        finish_checks("ferr_byte3", 32'h0102_0304);

        // Silent receiver: every byte times out; 1 + NB*(TO+1) cycles to done
        set_modes(M_MUTE, M_MUTE, M_MUTE, M_MUTE);
        run(32'hCAFE_F00D, -1, cyc);
        finish_checks("timeouts", 32'hCAFE_F00D);
        check("timeout_latency_window", (cyc >= 4*TO + 1) && (cyc <= 4*(TO+2) + 1), 1'b1);

        // Echo lands exactly on the timeout cycle; start poked while busy
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        dly[1] = TO - 1;
        run(32'h8899_AABB, 20, cyc);
        finish_checks("coincide_and_restart", 32'h8899_AABB);

        // Reset while waiting for the echo of byte 1
        set_modes(M_MUTE, M_MUTE, M_MUTE, M_MUTE);
        rsp_k = 0;
        sent_q.delete();
        @(negedge clk);
        msg   = 32'h1122_3344;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (sent_q.size() < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check("pre_reset_byte_idx", byte_idx, 2'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_run_reset_state",
              {Tx_DATA, Tx_WR, Tx_EN, Rx_EN, busy, done, pass, err_count, byte_idx}, '0);
        reset = 1'b0;
        @(negedge clk);

        set_modes(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        run(32'h5566_7788, -1, cyc);
        finish_checks("after_reset", 32'h5566_7788);

        // Randomized runs against the error-count model
        busy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NB; i++) begin
                mode[i] = ($urandom_range(0, 1) == 0) ? M_GOOD : int'($urandom_range(1, 4));
                dly[i]  = $urandom_range(0, TO - 1);
            end
            m = $urandom;
            run(m, $urandom_range(3, 60), cyc);
            finish_checks($sformatf("rand%0d", r), m);
        end
        busy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_loop_ctrl.md
UART_LOOP_CTRL -- requirements
Module: uart_loop_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving message length in bytes (1..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 200000, giving the maximum clk cycles allowed from Tx_WR to the matching Rx_VALID.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to send the message.
REQ-006 The block SHALL have port msg, input, 8*NBYTES, the message; byte k is msg[8k+7:8k], and byte 0 is sent first.
REQ-007 The block SHALL have port Tx_DATA, output, 8, the byte presented to the UART transmitter.
REQ-008 The block SHALL have port Tx_WR, output, 1, a one-cycle write strobe to the transmitter.
REQ-009 The block SHALL have ports Tx_EN and Rx_EN, outputs, 1 each, the transmitter and receiver enables.
REQ-010 The block SHALL have port Tx_BUSY, input, 1, the transmitter busy flag.
REQ-011 The block SHALL have ports Rx_DATA (input, 8), Rx_VALID (input, 1), Rx_PERROR (input, 1) and Rx_FERROR (input, 1), all taken from the receiver.
REQ-012 The block SHALL have port busy, output, 1, high from accepted start until DONE.
REQ-013 The block SHALL have port done, output, 1, a level that is high in DONE.
REQ-014 The block SHALL have port pass, output, 1, valid while done is high; it is 1 when err_count is 0.
REQ-015 The block SHALL have port err_count, output, $clog2(NBYTES+1), the number of failed bytes.
REQ-016 The block SHALL have port byte_idx, output, $clog2(NBYTES) (minimum 1), the index of the byte in flight.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND, WAIT_RX and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL latch msg into an internal register, clear byte_idx and err_count, and enter SEND on the next cycle.
REQ-019 start SHALL be ignored in SEND and WAIT_RX, and later changes to msg SHALL not affect a run in progress.
REQ-020 Tx_EN and Rx_EN SHALL be 1 in SEND and WAIT_RX, and 0 in IDLE and DONE.
REQ-021 In SEND with Tx_BUSY=0, the block SHALL drive Tx_DATA to the latched byte[byte_idx], assert Tx_WR for exactly one cycle, clear the timeout timer, and enter WAIT_RX.
REQ-022 In SEND with Tx_BUSY=1, the block SHALL hold in SEND with Tx_WR=0.
REQ-023 Tx_DATA SHALL remain stable from the Tx_WR cycle until the next Tx_WR.
REQ-024 Rx_VALID SHALL be edge-detected; only a 0->1 transition registered while in WAIT_RX counts as a reception, and edges in other states are discarded.
REQ-025 On a reception, the byte SHALL fail if Rx_DATA differs from byte[byte_idx], or if Rx_PERROR or Rx_FERROR is 1 in that cycle; a failure increments err_count.
REQ-026 In WAIT_RX, the timer SHALL increment each cycle; when it reaches TIMEOUT-1 with no reception, the byte fails and err_count increments.
REQ-027 If a reception and the timeout occur in the same cycle, the reception SHALL take priority and the timeout is not counted.
REQ-028 After a reception or timeout, if byte_idx = NBYTES-1 the block SHALL enter DONE; otherwise byte_idx increments and the block returns to SEND.
REQ-029 err_count SHALL never exceed NBYTES, and its increment SHALL not wrap.
REQ-030 In DONE, done=1, busy=0 and pass=(err_count==0), and the block SHALL hold these until start or reset.
REQ-031 Latency SHALL be one cycle from start to SEND, and one cycle from a Rx_VALID rising edge to err_count/byte_idx update.

Reset
REQ-032 When reset=1 at a clk edge, the block SHALL enter IDLE regardless of current state, including mid-byte.
REQ-033 Reset SHALL set Tx_DATA=0, Tx_WR=0, Tx_EN=0, Rx_EN=0, busy=0, done=0, pass=0, err_count=0, byte_idx=0, timer=0 and the edge-detect register=0.
REQ-034 start SHALL be ignored in any cycle where reset=1.

Structure
REQ-035 The FSM state encoding and the byte-width constant (8) SHALL live in the shared package uart_pkg.
REQ-036 The Rx_VALID edge detector and timeout timer SHALL be inline; no sub-module is required.
REQ-037 The block SHALL connect directly to the Tx/Rx ports of the existing UART top and share its baud_select externally.

Verification
REQ-038 Loopback to the UART top at baud_select=3'b111, msg=32'hA55A_0FF0, start pulse -> bytes F0,0F,5A,A5 are sent in order, then done=1, pass=1, err_count=0.
REQ-039 A model that returns 8'h00 for byte 2 -> err_count=1 and pass=0 at done.
REQ-040 A model that asserts Rx_PERROR with correct data on byte 0 -> err_count=1.
REQ-041 A model that never asserts Rx_VALID, with TIMEOUT=50 -> each byte times out after 50 cycles, err_count=4, and done follows about 4x51 cycles later.
REQ-042 Reset asserted in WAIT_RX of byte 1 -> all outputs at reset values the next cycle, and a following start runs cleanly.
REQ-043 A start pulse during busy, and a reception coinciding with the timeout cycle -> the start is ignored, and the reception is counted without a timeout failure.
